// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA constants and types: counter widths, colour
//               channel width, the packed RGB pixel type and the eight-entry
//               colour-bar table used by the optional test-pattern source.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int VGA_MAX_H_WIDTH = 11;
  localparam int VGA_MAX_V_WIDTH = 10;
  localparam int VGA_COLOR_W     = 4;

  typedef struct packed {
    logic [VGA_COLOR_W-1:0] r;
    logic [VGA_COLOR_W-1:0] g;
    logic [VGA_COLOR_W-1:0] b;
  } vga_rgb_t;

  localparam logic [VGA_COLOR_W-1:0] C_ON  = '1;
  localparam logic [VGA_COLOR_W-1:0] C_OFF = '0;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red,
  // blue, black.
  localparam vga_rgb_t [7:0] VGA_BAR_COLORS = {
    {C_OFF, C_OFF, C_OFF},   // 7 black
    {C_OFF, C_OFF, C_ON },   // 6 blue
    {C_ON , C_OFF, C_OFF},   // 5 red
    {C_ON , C_OFF, C_ON },   // 4 magenta
    {C_OFF, C_ON , C_OFF},   // 3 green
    {C_OFF, C_ON , C_ON },   // 2 cyan
    {C_ON , C_ON , C_OFF},   // 1 yellow
    {C_ON , C_ON , C_ON }    // 0 white
  };

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Fixed-depth shift register with asynchronous active-low
//               reset; every stage resets to RST_VAL.
// Revision    : 1.0 - initial release
// Ports       : clk_i   - clock
//               arstn_i - asynchronous reset, active low
//               d_i     - data in  [WIDTH]
//               q_o     - data out [WIDTH], DEPTH cycles after d_i
// ============================================================================
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_pipe
// Description : Pixel stage behind the VGA timing generator. Issues one
//               framebuffer read per display pixel, delays hs/vs/enable by the
//               read latency so they line up with returning data, and drives
//               registered RGB and sync to the pins (total latency
//               RD_LATENCY+1). RGB is blanked outside the display area.
//               Sticky err_o: [0] display pixel without read data (underflow),
//               [1] read data outside the display area (spurious).
// Revision    : 1.0 - initial release
// Option      : VGA_TEST_PATTERN_EN - adds pattern_sel_i; when high, pixels
//               come from an eight-bar colour pattern instead of memory.
// Ports       : clk_i, arstn_i                 clock, async active-low reset
//               vga_hs_i, vga_vs_i             sync in (low = sync)
//               pixel_enable_i                 display-area pixel
//               hcount_i, vcount_i             generator counters
//               fb_req_o, fb_addr_o            framebuffer read request/address
//               fb_rvalid_i, fb_rdata_i        read response {r,g,b}
//               err_clr_i, err_o               error clear / sticky flags
//               vga_hs_o, vga_vs_o             aligned sync out
//               vga_r_o, vga_g_o, vga_b_o      pixel colour
//               pattern_sel_i                  colour-bar select (option only)
// ============================================================================
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int FB_ADDR_W  = 19,
  parameter int COLOR_W    = 4,
  parameter int BAR_SHIFT  = 7
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       vga_hs_i,
  input  logic                       vga_vs_i,
  input  logic                       pixel_enable_i,
  input  logic [VGA_MAX_H_WIDTH-1:0] hcount_i,
  input  logic [VGA_MAX_V_WIDTH-1:0] vcount_i,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                       pattern_sel_i,
`endif
  output logic                       fb_req_o,
  output logic [FB_ADDR_W-1:0]       fb_addr_o,
  input  logic                       fb_rvalid_i,
  input  logic [3*COLOR_W-1:0]       fb_rdata_i,
  input  logic                       err_clr_i,
  output logic [1:0]                 err_o,
  output logic                       vga_hs_o,
  output logic                       vga_vs_o,
  output logic [COLOR_W-1:0]         vga_r_o,
  output logic [COLOR_W-1:0]         vga_g_o,
  output logic [COLOR_W-1:0]         vga_b_o
);

  // --------------------------------------------------------------------------
  // Pattern source select and delayed bar colour
  // --------------------------------------------------------------------------
  logic       pat_sel;
  logic       dly_pat;
  logic [2:0] dly_bar;    // {r,g,b} on/off of the bar at stage D

`ifdef VGA_TEST_PATTERN_EN
  logic [VGA_MAX_H_WIDTH-1:0] bar_pos;
  vga_rgb_t                   bar_rgb;
  logic [2:0]                 bar_on;

  assign pat_sel = pattern_sel_i;
  assign bar_pos = hcount_i >> BAR_SHIFT;
  assign bar_rgb = VGA_BAR_COLORS[bar_pos[2:0]];
  // Bar channels are either fully on or fully off.
  assign bar_on  = {|bar_rgb.r, |bar_rgb.g, |bar_rgb.b};

  // The select travels with the colour so a mid-line switch lands on
  // exactly the pixel where it happened.
  vga_delay_line #(
    .WIDTH   (4),
    .DEPTH   (RD_LATENCY),
    .RST_VAL (4'b0000)
  ) u_bar_dly (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .d_i     ({pat_sel, bar_on}),
    .q_o     ({dly_pat, dly_bar})
  );

  logic unused_inputs;
  assign unused_inputs = ^{vcount_i, bar_pos[VGA_MAX_H_WIDTH-1:3]};
`else
  assign pat_sel = 1'b0;
  assign dly_pat = 1'b0;
  assign dly_bar = 3'b000;

  logic unused_inputs;
  assign unused_inputs = ^{vcount_i, hcount_i, dly_bar};
`endif

  // --------------------------------------------------------------------------
  // Fetch request and address
  // --------------------------------------------------------------------------
  logic                 req;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;

  assign req       = pixel_enable_i & ~pat_sel;
  assign fb_req_o  = req;
  assign fb_addr_o = addr_q;

  // vsync low takes priority over an increment in the same cycle.
  always_comb begin
    addr_d = addr_q;
    if (!vga_vs_i) begin
      addr_d = '0;
    end else if (req) begin
      addr_d = addr_q + FB_ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sync/enable alignment to read data (stage D)
  // --------------------------------------------------------------------------
  logic dly_hs, dly_vs, dly_en;

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (RD_LATENCY),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .d_i     ({vga_hs_i, vga_vs_i, pixel_enable_i}),
    .q_o     ({dly_hs, dly_vs, dly_en})
  );

  // --------------------------------------------------------------------------
  // Output register and error flags
  // --------------------------------------------------------------------------
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic [1:0]           err_q, err_d;
  logic                 hs_q, vs_q;

  always_comb begin
    rgb_d = '0;
    err_d = err_q;
    // Clear first so a new error in the same cycle still sets its bit.
    if (err_clr_i) begin
      err_d = 2'b00;
    end
    if (dly_pat) begin
      // Pattern pixels never touch the memory path or the error flags.
      if (dly_en) begin
        rgb_d = {{COLOR_W{dly_bar[2]}}, {COLOR_W{dly_bar[1]}}, {COLOR_W{dly_bar[0]}}};
      end
    end else if (dly_en) begin
      if (fb_rvalid_i) begin
        rgb_d = fb_rdata_i;
      end else begin
        err_d[0] = 1'b1;
      end
    end else if (fb_rvalid_i) begin
      err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rgb_q <= '0;
      err_q <= 2'b00;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      err_q <= err_d;
      hs_q  <= dly_hs;
      vs_q  <= dly_vs;
    end
  end

  assign err_o    = err_q;
  assign vga_hs_o = hs_q;
  assign vga_vs_o = vs_q;
  assign vga_r_o  = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga_g_o  = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b_o  = rgb_q[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pixel_pipe
// Description : Self-checking bench for vga_pixel_pipe. A small timing
//               generator drives the pipe, a fixed-latency memory model
//               returns data = addr[11:0], and expected pin values are queued
//               when inputs are driven and popped RD_LATENCY+1 cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_pipe;

  localparam int RD_LAT = 2;
  localparam int AW     = 19;
  localparam int CW     = 4;
  localparam int PIPE   = RD_LAT + 1;

  // Reduced geometry keeps a frame short.
  localparam int H_ACT = 20, H_TOT = 28, HS_B = 22, HS_E = 25;
  localparam int V_ACT = 4,  V_TOT = 7,  VS_L = 5;

  logic          clk_i = 1'b0;
  logic          arstn_i = 1'b0;
  logic          vga_hs_i = 1'b1, vga_vs_i = 1'b1, pixel_enable_i = 1'b0;
  logic [10:0]   hcount_i = '0;
  logic [9:0]    vcount_i = '0;
  logic          fb_req_o;
  logic [AW-1:0] fb_addr_o;
  logic          fb_rvalid_i;
  logic [11:0]   fb_rdata_i;
  logic          err_clr_i = 1'b0;
  logic [1:0]    err_o;
  logic          vga_hs_o, vga_vs_o;
  logic [CW-1:0] vga_r_o, vga_g_o, vga_b_o;
  logic          pattern_sel_i = 1'b0;
  logic          pat_next = 1'b0;

  vga_pixel_pipe #(
    .RD_LATENCY (RD_LAT),
    .FB_ADDR_W  (AW),
    .COLOR_W    (CW),
    .BAR_SHIFT  (7)
  ) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .vga_hs_i       (vga_hs_i),
    .vga_vs_i       (vga_vs_i),
    .pixel_enable_i (pixel_enable_i),
    .hcount_i       (hcount_i),
    .vcount_i       (vcount_i),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel_i  (pattern_sel_i),
`endif
    .fb_req_o       (fb_req_o),
    .fb_addr_o      (fb_addr_o),
    .fb_rvalid_i    (fb_rvalid_i),
    .fb_rdata_i     (fb_rdata_i),
    .err_clr_i      (err_clr_i),
    .err_o          (err_o),
    .vga_hs_o       (vga_hs_o),
    .vga_vs_o       (vga_vs_o),
    .vga_r_o        (vga_r_o),
    .vga_g_o        (vga_g_o),
    .vga_b_o        (vga_b_o)
  );

  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------------------
  // Memory model: fixed latency, data = address[11:0]
  // --------------------------------------------------------------------------
  logic        drop_r = 1'b0;
  logic        inj_r  = 1'b0;
  logic [12:0] mem_pipe [RD_LAT] = '{default: '0};

  always @(posedge clk_i) begin
    mem_pipe[0] <= {fb_req_o & ~drop_r, fb_addr_o[11:0]};
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end

  assign fb_rvalid_i = mem_pipe[RD_LAT-1][12] | inj_r;
  assign fb_rdata_i  = inj_r ? 12'hFFF : mem_pipe[RD_LAT-1][11:0];

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] addr_m;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            req_cnt  = 0;
  int            h = 0, v = 0;

  function automatic logic [11:0] bar_color(input logic [10:0] hc);
    case (hc[9:7])
      3'd0: bar_color = 12'hFFF;
      3'd1: bar_color = 12'hFF0;
      3'd2: bar_color = 12'h0FF;
      3'd3: bar_color = 12'h0F0;
      3'd4: bar_color = 12'hF0F;
      3'd5: bar_color = 12'hF00;
      3'd6: bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

  task automatic prime();
    exp_t idle;
    idle.hs = 1'b1; idle.vs = 1'b1; idle.rgb = '0;
    sb.delete();
    for (int i = 0; i < PIPE; i++) sb.push_back(idle);
    addr_m = '0;
  endtask

  // One pixel clock: check pins against the oldest queued expectation,
  // drive new inputs, check the fetch port, queue the new expectation.
  task automatic cycle(input logic hs, input logic vs, input logic en,
                       input logic [10:0] hc, input logic [9:0] vc,
                       input logic drop, input logic inj, input logic clr);
    exp_t e;
    exp_t got;
    logic exp_req;
    @(posedge clk_i); #1;
    e   = sb.pop_front();
    got = {vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pins @%0t: got hs=%b vs=%b rgb=%h, expected hs=%b vs=%b rgb=%h",
               $time, got.hs, got.vs, got.rgb, e.hs, e.vs, e.rgb);
    end
    vga_hs_i = hs; vga_vs_i = vs; pixel_enable_i = en;
    hcount_i = hc; vcount_i = vc;
    drop_r = drop; inj_r = inj; err_clr_i = clr;
    pattern_sel_i = pat_next;
    #1;
    exp_req = en & ~pattern_sel_i;
    n_checks++;
    if ({fb_req_o, fb_addr_o} !== {exp_req, addr_m}) begin
      n_fail++;
      $display("FAIL fetch @%0t: got req=%b addr=%0d, expected req=%b addr=%0d",
               $time, fb_req_o, fb_addr_o, exp_req, addr_m);
    end
    if (fb_req_o === 1'b1) req_cnt++;
    e.hs  = hs;
    e.vs  = vs;
    e.rgb = (en && !drop) ? addr_m[11:0] : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel_i) e.rgb = en ? bar_color(hc) : 12'h000;
`endif
    sb.push_back(e);
    if (!vs)          addr_m = '0;
    else if (exp_req) addr_m = addr_m + 1'b1;
  endtask

  task automatic gen(input logic drop, input logic inj, input logic clr);
    cycle(!(h >= HS_B && h < HS_E), v != VS_L, (h < H_ACT) && (v < V_ACT),
          11'(h), 10'(v), drop, inj, clr);
    h++;
    if (h == H_TOT) begin
      h = 0;
      v++;
      if (v == V_TOT) v = 0;
    end
  endtask

  task automatic goto(input int hh, input int vv);
    while (!(h == hh && v == vv)) gen(1'b0, 1'b0, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    arstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o} !== {2'b11, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_pins: got hs=%b vs=%b rgb=%h%h%h, expected 1 1 000",
               vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o);
    end
    n_checks++;
    if ({fb_req_o, fb_addr_o, err_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_fetch: got req=%b addr=%0d err=%b, expected 0 0 00",
               fb_req_o, fb_addr_o, err_o);
    end
    @(negedge clk_i);
    arstn_i = 1'b1;
    prime();
    h = 0; v = 0;
  endtask

  task automatic test_frame();
    for (int f = 0; f < 2; f++) begin
      req_cnt = 0;
      repeat (H_TOT * V_TOT) gen(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (req_cnt != H_ACT * V_ACT) begin
        n_fail++;
        $display("FAIL frame_req_count: got %0d, expected %0d", req_cnt, H_ACT * V_ACT);
      end
    end
    gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fb_addr_o !== '0 || fb_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start_addr: got req=%b addr=%0d, expected 1 0", fb_req_o, fb_addr_o);
    end
  endtask

  task automatic test_underflow();
    goto(5, 1);
    gen(1'b1, 1'b0, 1'b0);
    repeat (6) gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b01) begin
      n_fail++;
      $display("FAIL underflow_set: got err=%b, expected 01", err_o);
    end
    repeat (40) gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b01) begin
      n_fail++;
      $display("FAIL underflow_sticky: got err=%b, expected 01", err_o);
    end
    gen(1'b0, 1'b0, 1'b1);
    gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL underflow_clear: got err=%b, expected 00", err_o);
    end
  endtask

  task automatic test_spurious();
    while (h != H_ACT + 4) gen(1'b0, 1'b0, 1'b0);
    gen(1'b0, 1'b1, 1'b0);
    gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b10) begin
      n_fail++;
      $display("FAIL spurious_set: got err=%b, expected 10", err_o);
    end
    gen(1'b0, 1'b0, 1'b0);
    while (h != H_ACT + 4) gen(1'b0, 1'b0, 1'b0);
    gen(1'b0, 1'b1, 1'b1);
    gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b10) begin
      n_fail++;
      $display("FAIL spurious_set_wins: got err=%b, expected 10", err_o);
    end
    gen(1'b0, 1'b0, 1'b1);
    gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL spurious_clear: got err=%b, expected 00", err_o);
    end
  endtask

  task automatic test_reset_midline();
    while (h != H_ACT + 4) gen(1'b0, 1'b0, 1'b0);
    gen(1'b0, 1'b1, 1'b0);
    goto(10, 1);
    @(negedge clk_i);
    arstn_i = 1'b0;
    vga_hs_i = 1'b1; vga_vs_i = 1'b1; pixel_enable_i = 1'b0;
    drop_r = 1'b0; inj_r = 1'b0; err_clr_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if ({vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o, err_o} !== {2'b11, 12'h000, 2'b00}) begin
      n_fail++;
      $display("FAIL midline_reset_pins: got hs=%b vs=%b rgb=%h%h%h err=%b, expected 1 1 000 00",
               vga_hs_o, vga_vs_o, vga_r_o, vga_g_o, vga_b_o, err_o);
    end
    n_checks++;
    if ({fb_req_o, fb_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL midline_reset_fetch: got req=%b addr=%0d, expected 0 0", fb_req_o, fb_addr_o);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    arstn_i = 1'b1;
    prime();
    goto(0, 0);
    gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fb_addr_o !== '0 || fb_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midline_next_frame_addr: got req=%b addr=%0d, expected 1 0", fb_req_o, fb_addr_o);
    end
    repeat (H_TOT) gen(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL midline_err_after: got err=%b, expected 00", err_o);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    pat_next = 1'b1;
    for (int k = 0; k < 32; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 11'(k * 32), 10'd0, 1'b0, 1'b0, 1'b0);
    end
    repeat (PIPE) cycle(1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    pat_next = 1'b0;
    repeat (PIPE) cycle(1'b1, 1'b1, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL pattern_err: got err=%b, expected 00", err_o);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_underflow();
    test_spurious();
    test_reset_midline();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
